debounce_events: RTL and testbench
==================================

// Module: debounce_events
// PURPOSE
//  Multi-channel push-button debouncer. Each channel has its own integrating
//  counter and detects press, release and long-press (hold) events. Events
//  leave on a valid/ready stream, lowest channel first. Sits between board
//  button pins and a CPU-facing event FIFO or interrupt peripheral.
// PARAMETERS
//  NIN            8      number of channels, 1..32
//  LGTICK         10     shared prescaler; one tick every 2^LGTICK clocks
//  DEB_TICKS      100    consecutive ticks a new level must persist, >=1
//  HOLD_TICKS     1000   ticks pressed (after acceptance) before hold, >=1
//  OPT_ACTIVE_LOW 1'b0   1: pin low = pressed (inverted after synchroniser)
// PORTS
//  i_clk        in   1       clock
//  i_reset_n    in   1       reset; synchronous, active-low
//  i_in         in   NIN     raw asynchronous button pins
//  o_debounced  out  NIN     debounced level, 1 = pressed
//  o_held       out  NIN     1 while pressed for >= HOLD_TICKS
//  o_evt_valid  out  1       event word valid
//  i_evt_ready  in   1       consumer accepts the event word
//  o_evt_chan   out  CW      channel index, CW = max(1,$clog2(NIN))
//  o_evt_kind   out  2       01 press, 10 release, 11 hold
//  o_overrun    out  1       sticky: an event was lost
// BEHAVIOUR
//  - Reset (i_reset_n low at posedge): prescaler, counters and pending bits
//    clear. o_debounced, o_held, o_evt_valid, o_evt_chan, o_evt_kind and
//    o_overrun all go to 0. Sync FFs load OPT_ACTIVE_LOW, so s = 0.
//  - Sync: 2-FF chain per channel; s = sync_out ^ OPT_ACTIVE_LOW.
//  - Prescaler: free-running LGTICK-bit counter; tick is high for 1 clock
//    when the counter is all ones.
//  - Debounce counter, $clog2(DEB_TICKS+1) bits:
//    - if s == o_debounced: clears on any clock.
//    - otherwise: increments on tick.
//    - on tick with count == DEB_TICKS-1: o_debounced <= s and count <= 0.
//    - a glitch shorter than DEB_TICKS ticks never reaches the output.
//    - latency, pin edge to o_debounced: 3 + [(DEB_TICKS-1)*2^LGTICK+1,
//      DEB_TICKS*2^LGTICK] clocks.
//  - Hold counter:
//    - counts ticks while o_debounced=1 and o_held=0.
//    - on tick at HOLD_TICKS-1: o_held <= 1.
//    - counter and o_held clear on the clock o_debounced falls.
//  - Pending bits, three per channel (press, hold, release):
//    - set on o_debounced rise, o_held rise, o_debounced fall respectively.
//    - raise while that bit is already pending: bit stays set and
//      o_overrun <= 1 (sticky until reset).
//    - raise and issue of the same bit in one clock: bit stays set, no
//      overrun.
//  - Output register:
//    - loads when !o_evt_valid || i_evt_ready.
//    - selects the lowest channel with any pending bit; within a channel,
//      priority is press > hold > release.
//    - the issued bit clears on the load clock.
//    - nothing pending at load: o_evt_valid <= 0.
//    - while valid && !ready: valid, chan and kind are held stable.
//    - no combinational path from i_evt_ready to outputs.
//    - throughput is 1 event/clock while ready is held high.
//  - Reset mid-operation drops the current event and all pending events,
//    does not set overrun, and produces no spurious events afterwards.
// STRUCTURE
//  - Package debounce_pkg: EVT_NONE=2'b00, EVT_PRESS=2'b01,
//    EVT_RELEASE=2'b10, EVT_HOLD=2'b11.
//  - Sub-module debounce_chan, one per channel: sync, debounce counter,
//    hold counter, edge strobes (rise/fall/held).
//  - Top level: prescaler, NIN debounce_chan instances, pending bits,
//    priority select, output register.
// TESTING  (NIN=4, LGTICK=2, DEB_TICKS=3, HOLD_TICKS=5, ready=1 unless noted)
//  1. Clean press on ch2 for 40 clocks, then release -> o_debounced[2] rises
//     12..15 clocks after the edge; events, in order: {2,press};
//     {2,hold} 17..20 clocks after the rise; {2,release} after the release.
//  2. ch1 glitch of 6 clocks -> o_debounced unchanged, no events, no overrun.
//  3. ready=0; ch0 and ch3 pressed together -> valid holds {0,press} stable;
//     raise ready -> {0,press} then {3,press} on consecutive clocks, then
//     valid drops.
//  4. ready=0; ch1 pressed/released twice -> o_overrun=1 and stays 1; reset
//     clears it.
//  5. OPT_ACTIVE_LOW=1, pins idle high through and after reset -> all
//     outputs 0, no events; pin low for 15 clocks -> {0,press}.
//  6. Reset pulse while valid=1 with pending events -> next clock all
//     outputs 0; after release with pins idle, no events for 100 clocks.

Source files
------------

// File: rtl/debounce_pkg.sv
// Purpose: shared event encodings and helpers for the push-button debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_pkg;

    // Event kind carried on the output stream.
    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_HOLD    = 2'b11
    } evt_kind_t;

    // One pending flag per event kind for a single channel.
    // Field order matches issue priority: press > hold > release.
    typedef struct packed {
        logic prs;
        logic hld;
        logic rel;
    } pend_t;

    // Channel-index width; a single channel still needs one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Purpose: one button channel: 2-FF synchroniser, integrating debounce counter, hold counter, edge strobes.
// Latency: pin edge to o_debounced = 3 + [(DEB_TICKS-1)*tick_period+1, DEB_TICKS*tick_period] clocks.
// Backpressure: none; strobes are single-clock pulses and must be captured by the caller.
// Ports: i_clk, i_reset_n (sync, active-low), i_pin (raw async pin), i_tick (prescaler strobe),
//        o_debounced / o_held (levels), o_rise / o_fall / o_hold_rise (pulses on the clock the level changes).
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEB_TICKS      = 100,
    parameter int HOLD_TICKS     = 1000,
    parameter bit OPT_ACTIVE_LOW = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    input  logic i_tick,
    output logic o_debounced,
    output logic o_held,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold_rise
);

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic [1:0]    sync_q;
    logic          lvl_q;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          flip;
    logic          hold_hit;

    // The synchronised level is retimed once more so the pin-to-counter
    // pipeline is a fixed three clocks; the counter then only sees a clean,
    // polarity-corrected level.
    assign flip     = i_tick && (lvl_q != o_debounced) && (deb_cnt == DW'(DEB_TICKS - 1));
    // A fall on the same tick wins over reaching the hold threshold.
    assign hold_hit = i_tick && o_debounced && !o_held && !flip
                      && (hold_cnt == HW'(HOLD_TICKS - 1));

    assign o_rise      = flip && !o_debounced;
    assign o_fall      = flip && o_debounced;
    assign o_hold_rise = hold_hit;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_q      <= {2{OPT_ACTIVE_LOW}};
            lvl_q       <= 1'b0;
            deb_cnt     <= '0;
            o_debounced <= 1'b0;
            hold_cnt    <= '0;
            o_held      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_pin};
            lvl_q  <= sync_q[1] ^ OPT_ACTIVE_LOW;

            // Any clock where the level agrees with the output restarts the
            // integration, so a glitch has to persist for a full run of ticks.
            if (lvl_q == o_debounced) begin
                deb_cnt <= '0;
            end else if (i_tick) begin
                if (flip) begin
                    o_debounced <= lvl_q;
                    deb_cnt     <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            if (o_fall) begin
                hold_cnt <= '0;
                o_held   <= 1'b0;
            end else if (i_tick && o_debounced && !o_held) begin
                if (hold_hit) begin
                    o_held <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debounce_events.sv
// Purpose: multi-channel debouncer emitting press/hold/release events, lowest channel first.
// Latency: event word appears 1 clock after the level change that raised it (if the stream is free).
// Backpressure: valid/ready; pending flags absorb one event per kind per channel, a second sets o_overrun.
// Ports: i_clk, i_reset_n (sync, active-low), i_in[NIN] raw pins, o_debounced/o_held[NIN] levels,
//        o_evt_valid/i_evt_ready stream handshake with o_evt_chan/o_evt_kind payload, o_overrun sticky loss flag.
module debounce_events
    import debounce_pkg::*;
#(
    parameter int NIN            = 8,
    parameter int LGTICK         = 10,
    parameter int DEB_TICKS      = 100,
    parameter int HOLD_TICKS     = 1000,
    parameter bit OPT_ACTIVE_LOW = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [NIN-1:0]              i_in,
    output logic [NIN-1:0]              o_debounced,
    output logic [NIN-1:0]              o_held,
    output logic                        o_evt_valid,
    input  logic                        i_evt_ready,
    output logic [chan_width(NIN)-1:0]  o_evt_chan,
    output logic [1:0]                  o_evt_kind,
    output logic                        o_overrun
);

    localparam int CW = chan_width(NIN);

    logic [LGTICK-1:0] presc_q;
    logic              tick;

    logic [NIN-1:0]    rise_v;
    logic [NIN-1:0]    fall_v;
    logic [NIN-1:0]    hold_v;

    pend_t [NIN-1:0]   raise;
    pend_t [NIN-1:0]   pend_q;
    pend_t [NIN-1:0]   pend_d;
    pend_t [NIN-1:0]   issue;
    pend_t [NIN-1:0]   issue_eff;

    logic              load;
    logic              sel_found;
    logic [CW-1:0]     sel_chan;
    evt_kind_t         sel_kind;
    logic              ovr_hit;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = &presc_q;

    for (genvar g = 0; g < NIN; g++) begin : g_chan
        debounce_chan #(
            .DEB_TICKS      (DEB_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .OPT_ACTIVE_LOW (OPT_ACTIVE_LOW)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset_n   (i_reset_n),
            .i_pin       (i_in[g]),
            .i_tick      (tick),
            .o_debounced (o_debounced[g]),
            .o_held      (o_held[g]),
            .o_rise      (rise_v[g]),
            .o_fall      (fall_v[g]),
            .o_hold_rise (hold_v[g])
        );
    end

    always_comb begin
        raise = '0;
        for (int i = 0; i < NIN; i++) begin
            raise[i].prs = rise_v[i];
            raise[i].hld = hold_v[i];
            raise[i].rel = fall_v[i];
        end
    end

    // Lowest channel with anything pending; inside it, press > hold > release.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        sel_kind  = EVT_NONE;
        issue     = '0;
        for (int i = 0; i < NIN; i++) begin
            if (!sel_found && (pend_q[i] != '0)) begin
                sel_found = 1'b1;
                sel_chan  = CW'(i);
                if (pend_q[i].prs) begin
                    sel_kind     = EVT_PRESS;
                    issue[i].prs = 1'b1;
                end else if (pend_q[i].hld) begin
                    sel_kind     = EVT_HOLD;
                    issue[i].hld = 1'b1;
                end else begin
                    sel_kind     = EVT_RELEASE;
                    issue[i].rel = 1'b1;
                end
            end
        end
    end

    // The output word is fully registered, so ready only gates the load.
    assign load      = !o_evt_valid || i_evt_ready;
    assign issue_eff = load ? issue : '0;
    // A raise landing on a bit that is leaving this clock just re-arms it.
    assign pend_d    = (pend_q & ~issue_eff) | raise;
    assign ovr_hit   = |(raise & pend_q & ~issue_eff);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pend_q      <= '0;
            o_evt_valid <= 1'b0;
            o_evt_chan  <= '0;
            o_evt_kind  <= EVT_NONE;
            o_overrun   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (ovr_hit) begin
                o_overrun <= 1'b1;
            end
            if (load) begin
                o_evt_valid <= sel_found;
                o_evt_chan  <= sel_chan;
                o_evt_kind  <= sel_kind;
            end
        end
    end

endmodule

// File: tb/tb_debounce_events.sv
// Purpose: directed self-checking bench for debounce_events (active-high and active-low instances).
// Latency: n/a.
// Backpressure: ready on the active-high instance is toggled by the stimulus; the active-low one is always ready.
module tb_debounce_events;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pin_a, pin_b;
    logic [3:0] deb_a, held_a, deb_b, held_b;
    logic       vld_a, rdy_a, ovr_a;
    logic       vld_b, rdy_b, ovr_b;
    logic [1:0] chan_a, kind_a, chan_b, kind_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 clk = ~clk;

    debounce_events #(
        .NIN(4), .LGTICK(2), .DEB_TICKS(3), .HOLD_TICKS(5), .OPT_ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_in(pin_a),
        .o_debounced(deb_a), .o_held(held_a),
        .o_evt_valid(vld_a), .i_evt_ready(rdy_a),
        .o_evt_chan(chan_a), .o_evt_kind(kind_a), .o_overrun(ovr_a)
    );

    debounce_events #(
        .NIN(4), .LGTICK(2), .DEB_TICKS(3), .HOLD_TICKS(5), .OPT_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_in(pin_b),
        .o_debounced(deb_b), .o_held(held_b),
        .o_evt_valid(vld_b), .i_evt_ready(rdy_b),
        .o_evt_chan(chan_b), .o_evt_kind(kind_b), .o_overrun(ovr_b)
    );

    // Record every word that is accepted at the coming rising edge.
    always @(negedge clk) begin
        if (vld_a && rdy_a) q_a.push_back({chan_a, kind_a});
        if (vld_b && rdy_b) q_b.push_back({chan_b, kind_b});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n clocks and settle just after the last rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // which: 0 = deb_a, 1 = held_a. Returns the clock count at which the bit reached lvl,
    // or maxc+1 if it never did.
    task automatic wait_bit(input int which, input int ch, input logic lvl, input int maxc, output int n);
        logic b;
        n = maxc + 1;
        for (int k = 1; k <= maxc; k++) begin
            step(1);
            b = (which == 0) ? deb_a[ch] : held_a[ch];
            if (b == lvl) begin
                n = k;
                break;
            end
        end
    endtask

    // Pop one recorded event {chan,kind}; an empty queue reads as 5'h10.
    task automatic pop_chk(input string tag, input int which, input logic [3:0] exp);
        logic [4:0] got;
        got = 5'h10;
        if (which == 0) begin
            if (q_a.size() > 0) got = {1'b0, q_a.pop_front()};
        end else begin
            if (q_b.size() > 0) got = {1'b0, q_b.pop_front()};
        end
        chk_eq(tag, got, {1'b0, exp});
    endtask

    initial begin
        int n;
        int m;
        logic seen;

        rst_n = 1'b0;
        pin_a = 4'h0;
        pin_b = 4'hF;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        step(3);

        // Reset state of both instances.
        chk_eq("rst_deb_a",  deb_a,  0);
        chk_eq("rst_held_a", held_a, 0);
        chk_eq("rst_vld_a",  vld_a,  0);
        chk_eq("rst_chan_a", chan_a, 0);
        chk_eq("rst_kind_a", kind_a, 0);
        chk_eq("rst_ovr_a",  ovr_a,  0);
        chk_eq("rst_deb_b",  deb_b,  0);
        chk_eq("rst_vld_b",  vld_b,  0);
        rst_n = 1'b1;
        step(30);
        chk_eq("idle_q_a",   q_a.size(), 0);
        chk_eq("idle_q_b",   q_b.size(), 0);
        chk_eq("idle_deb_b", deb_b, 0);
        chk_eq("idle_ovr_b", ovr_b, 0);

        // 1: clean press on ch2 -> press, hold, release.
        pin_a[2] = 1'b1;
        wait_bit(0, 2, 1'b1, 30, n);
        chk_eq("t1_deb_lat", n, clamp(n, 12, 15));
        wait_bit(1, 2, 1'b1, 30, m);
        chk_eq("t1_hold_lat", m, clamp(m, 17, 20));
        if (n + m < 40) step(40 - n - m);
        pin_a[2] = 1'b0;
        step(30);
        chk_eq("t1_deb_clr",  deb_a[2],  0);
        chk_eq("t1_held_clr", held_a[2], 0);
        pop_chk("t1_ev_press", 0, {2'd2, 2'b01});
        pop_chk("t1_ev_hold",  0, {2'd2, 2'b11});
        pop_chk("t1_ev_rel",   0, {2'd2, 2'b10});
        chk_eq("t1_q_empty", q_a.size(), 0);

        // 2: 6-clock glitch on ch1 is filtered out.
        seen = 1'b0;
        pin_a[1] = 1'b1;
        step(6);
        pin_a[1] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            seen = seen | deb_a[1];
        end
        chk_eq("t2_deb_seen", seen, 0);
        chk_eq("t2_q_empty",  q_a.size(), 0);
        chk_eq("t2_ovr",      ovr_a, 0);

        // 3: simultaneous presses on ch0 and ch3 with the stream stalled.
        rdy_a = 1'b0;
        pin_a = 4'b1001;
        wait_bit(0, 0, 1'b1, 30, n);
        chk_eq("t3_deb_both", deb_a, 4'b1001);
        step(2);
        chk_eq("t3_vld",  vld_a,  1);
        chk_eq("t3_chan", chan_a, 0);
        chk_eq("t3_kind", kind_a, 1);
        step(5);
        chk_eq("t3_vld_hold",  vld_a,  1);
        chk_eq("t3_chan_hold", chan_a, 0);
        chk_eq("t3_kind_hold", kind_a, 1);
        rdy_a = 1'b1;
        step(1);
        chk_eq("t3_vld_2nd",  vld_a,  1);
        chk_eq("t3_chan_2nd", chan_a, 3);
        chk_eq("t3_kind_2nd", kind_a, 1);
        step(1);
        chk_eq("t3_vld_drop", vld_a, 0);
        pop_chk("t3_ev0", 0, {2'd0, 2'b01});
        pop_chk("t3_ev1", 0, {2'd3, 2'b01});
        pin_a = 4'b0000;
        step(30);
        pop_chk("t3_hold0", 0, {2'd0, 2'b11});
        pop_chk("t3_hold3", 0, {2'd3, 2'b11});
        pop_chk("t3_rel0",  0, {2'd0, 2'b10});
        pop_chk("t3_rel3",  0, {2'd3, 2'b10});

        // 4: repeated press/release on ch1 while stalled -> sticky overrun.
        rdy_a = 1'b0;
        for (int r = 0; r < 2; r++) begin
            pin_a[1] = 1'b1;
            step(16);
            pin_a[1] = 1'b0;
            step(16);
        end
        step(20);
        chk_eq("t4_ovr",       ovr_a,  1);
        chk_eq("t4_head_chan", chan_a, 1);
        chk_eq("t4_head_kind", kind_a, 1);
        step(10);
        chk_eq("t4_ovr_sticky", ovr_a, 1);
        rst_n = 1'b0;
        step(1);
        chk_eq("t4_ovr_rst", ovr_a, 0);
        chk_eq("t4_vld_rst", vld_a, 0);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        step(30);
        chk_eq("t4_q_after_rst", q_a.size(), 0);
        chk_eq("t4_q_b_quiet",   q_b.size(), 0);

        // 5: active-low instance, pin low for 15 clocks.
        pin_b[0] = 1'b0;
        step(15);
        pin_b[0] = 1'b1;
        step(40);
        pop_chk("t5_ev_press", 1, {2'd0, 2'b01});
        pop_chk("t5_ev_rel",   1, {2'd0, 2'b10});
        chk_eq("t5_deb_b", deb_b, 0);
        chk_eq("t5_ovr_b", ovr_b, 0);

        // 6: reset while an event is presented and others are pending.
        rdy_a = 1'b0;
        pin_a = 4'b1101;
        step(20);
        pin_a = 4'b0000;
        step(25);
        chk_eq("t6_pre_vld", vld_a, 1);
        rst_n = 1'b0;
        step(1);
        chk_eq("t6_deb",  deb_a,  0);
        chk_eq("t6_held", held_a, 0);
        chk_eq("t6_vld",  vld_a,  0);
        chk_eq("t6_chan", chan_a, 0);
        chk_eq("t6_kind", kind_a, 0);
        chk_eq("t6_ovr",  ovr_a,  0);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        step(100);
        chk_eq("t6_no_events", q_a.size(), 0);
        chk_eq("t6_ovr_after", ovr_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
